// File: rtl/bcd_conv_arbiter_if.sv
// Requester/display bus for the shared binary-to-BCD converter.
// The master modport is the requester/display side, and the slave modport is the converter.
interface bcd_conv_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [1:0]        done_id;
    logic [3:0]        d1;
    logic [3:0]        d10;
    logic [3:0]        d100;
    logic              ovf;

    modport master (
        output req, data,
        input  gnt, busy, done, done_id, d1, d10, d100, ovf
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_id, d1, d10, d100, ovf
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared double-dabble converter: an 8-bit value becomes three BCD digits in 8 shifts.
// Optional macro BCD_CLAMP99_EN saturates results above 99 to 0/9/9 for two-digit displays.
module bcd_conv_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_conv_arbiter_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      opnd_q, opnd_d;
    logic [11:0]     bcd_q, bcd_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      cur_id_q, cur_id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            done_q, done_d;
    logic [1:0]      done_id_q, done_id_d;
    logic [3:0]      d1_q, d1_d, d10_q, d10_d, d100_q, d100_d;
    logic            ovf_q, ovf_d;
    logic [2:0]      pick_s;
    logic [11:0]     step_s;

    // One double-dabble step: add 3 to every nibble that is 5 or more, then shift in the next bit.
    function automatic logic [11:0] bcd_step(input logic [11:0] b, input logic in_bit);
        logic [11:0] a;
        a = b;
        for (int n = 0; n < 3; n++) begin
            if (a[4*n +: 4] >= 4'd5) begin
                a[4*n +: 4] = a[4*n +: 4] + 4'd3;
            end else begin
                a[4*n +: 4] = a[4*n +: 4];
            end
        end
        return {a[10:0], in_bit};
    endfunction

    // Returns {found, index}. The nearest requester after the last grant wins.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NREQ);
            if (r[idx]) begin
                rr_pick = {1'b1, idx};
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    // State and output registers. Reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            opnd_q    <= 8'd0;
            bcd_q     <= 12'd0;
            last_q    <= 2'(NREQ - 1);
            cur_id_q  <= 2'd0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= 2'd0;
            d1_q      <= 4'd0;
            d10_q     <= 4'd0;
            d100_q    <= 4'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            bcd_q     <= bcd_d;
            last_q    <= last_d;
            cur_id_q  <= cur_id_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            d1_q      <= d1_d;
            d10_q     <= d10_d;
            d100_q    <= d100_d;
            ovf_q     <= ovf_d;
        end
    end

    // Arbitration, shift sequencing and result loading.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        bcd_d     = bcd_q;
        last_d    = last_q;
        cur_id_d  = cur_id_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        d1_d      = d1_q;
        d10_d     = d10_q;
        d100_d    = d100_q;
        ovf_d     = ovf_q;
        pick_s    = rr_pick(bus.req, last_q);
        step_s    = bcd_step(bcd_q, opnd_q[7]);
        case (state_q)
            IDLE: begin
                if (pick_s[2]) begin
                    gnt_d[pick_s[1:0]] = 1'b1;
                    opnd_d   = bus.data[8*pick_s[1:0] +: 8];
                    bcd_d    = 12'd0;
                    cnt_d    = 3'd0;
                    last_d   = pick_s[1:0];
                    cur_id_d = pick_s[1:0];
                    state_d  = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                opnd_d = {opnd_q[6:0], 1'b0};
                bcd_d  = step_s;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    done_id_d = cur_id_q;
                    ovf_d     = (step_s[11:8] != 4'd0);
`ifdef BCD_CLAMP99_EN
                    if (step_s[11:8] != 4'd0) begin
                        d100_d = 4'd0;
                        d10_d  = 4'd9;
                        d1_d   = 4'd9;
                    end else begin
                        d100_d = step_s[11:8];
                        d10_d  = step_s[7:4];
                        d1_d   = step_s[3:0];
                    end
`else
                    d100_d = step_s[11:8];
                    d10_d  = step_s[7:4];
                    d1_d   = step_s[3:0];
`endif
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.d1      = d1_q;
    assign bus.d10     = d10_q;
    assign bus.d100    = d100_q;
    assign bus.ovf     = ovf_q;
endmodule
